// File: rtl/bridge_pkg.sv
// -----------------------------------------------------------------------------
// bridge_pkg
// Shared types and constants for the I/O bus bridge: the bridge FSM state
// encoding, bus widths, the default window base address and a constant
// ceil-log2 helper used to size index and counter fields.
// -----------------------------------------------------------------------------
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_7F00;

  // Ceil-log2 with a floor of 1 so that a single-entry field still has a bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/bridge_decoder.sv
// -----------------------------------------------------------------------------
// bridge_decoder
// Combinational address decoder: maps a CPU word address onto one of N_DEV
// equal windows starting at BASE_ADDR.
//   cpuAddr : word address from the CPU
//   hit     : address falls inside one of the windows
//   idx     : window (device) index, valid when hit
//   offset  : word offset within the window
// -----------------------------------------------------------------------------
module bridge_decoder
  import bridge_pkg::*;
#(
  parameter int          N_DEV          = 4,
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter int          WIN_WORDS_LOG2 = 2,
  localparam int         IDX_W          = clog2(N_DEV)
) (
  input  logic [31:2]               cpuAddr,
  output logic                      hit,
  output logic [IDX_W-1:0]          idx,
  output logic [WIN_WORDS_LOG2+1:2] offset
);

  logic [31:0] byteOff;
  logic [31:0] winIdx;

  // Unsigned subtraction: an address below the base wraps to a huge offset,
  // and the explicit lower-bound compare keeps it from aliasing a window.
  assign byteOff = {cpuAddr, 2'b00} - BASE_ADDR;
  assign winIdx  = byteOff >> (WIN_WORDS_LOG2 + 2);

  assign hit    = (cpuAddr >= BASE_ADDR[31:2]) && (winIdx < 32'(N_DEV));
  assign idx    = winIdx[IDX_W-1:0];
  assign offset = byteOff[WIN_WORDS_LOG2+1:2];

endmodule

// File: rtl/io_bus_bridge.sv
// -----------------------------------------------------------------------------
// io_bus_bridge
// Bridges the CPU data port to N_DEV memory-mapped peripherals, one address
// window each. A request is decoded in IDLE; a hit latches the access into the
// dev_* registers and waits in ACCESS for the selected device's ack, a miss
// goes straight to RESP with an error. RESP emits a one-cycle cpu_ready.
//
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   cpu_req/we/addr/be/wdata : CPU request, held until cpu_ready
//   cpu_rdata, cpu_ready, cpu_err : registered completion and read data
//   dev_sel             : one-hot device strobe, high for the whole ACCESS
//   dev_we/be/addr/wdata: latched access attributes for the devices
//   dev_rdata, dev_ack  : flattened device read data and per-device ack
//   err_addr            : word address of the most recent failed access
//
// Build option: define BRIDGE_TIMEOUT_EN to abort an ACCESS that has waited
// TIMEOUT_CYCLES cycles without an ack (reported as an error).
// -----------------------------------------------------------------------------
module io_bus_bridge
  import bridge_pkg::*;
#(
  parameter int          N_DEV          = 4,
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter int          WIN_WORDS_LOG2 = 2,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [31:2]               cpu_addr,
  input  logic [BE_W-1:0]           cpu_be,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_ready,
  output logic                      cpu_err,
  output logic [N_DEV-1:0]          dev_sel,
  output logic                      dev_we,
  output logic [BE_W-1:0]           dev_be,
  output logic [WIN_WORDS_LOG2+1:2] dev_addr,
  output logic [DATA_W-1:0]         dev_wdata,
  input  logic [N_DEV*DATA_W-1:0]   dev_rdata,
  input  logic [N_DEV-1:0]          dev_ack,
  output logic [31:2]               err_addr
);

  localparam int IDX_W = clog2(N_DEV);

  state_t                    state;
  logic                      decHit;
  logic [IDX_W-1:0]          decIdx;
  logic [WIN_WORDS_LOG2+1:2] decOffset;
  logic [DATA_W-1:0]         selRdata;
  logic                      ackHit;

  bridge_decoder #(
    .N_DEV          (N_DEV),
    .BASE_ADDR      (BASE_ADDR),
    .WIN_WORDS_LOG2 (WIN_WORDS_LOG2)
  ) uDecoder (
    .cpuAddr (cpu_addr),
    .hit     (decHit),
    .idx     (decIdx),
    .offset  (decOffset)
  );

  // dev_sel is one-hot and zero outside ACCESS, so masking with it both picks
  // the selected device and ignores acks from every other device.
  assign ackHit = |(dev_ack & dev_sel);

  always_comb begin
    // NOTE: default first so every path assigns selRdata and no latch is inferred.
    selRdata = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (dev_sel[i]) begin
        selRdata = selRdata | dev_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] waitCnt;
  logic [31:2]      reqAddr;
  logic             timeoutHit;

  // Fires on the TIMEOUT_CYCLES-th ACCESS cycle without an ack.
  assign timeoutHit = (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // NOTE: reset is asynchronous and clears every output register, so dev_sel
  // drops the moment rst_n falls even in the middle of an access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      dev_sel   <= '0;
      dev_we    <= 1'b0;
      dev_be    <= '0;
      dev_addr  <= '0;
      dev_wdata <= '0;
      err_addr  <= '0;
`ifdef BRIDGE_TIMEOUT_EN
      waitCnt   <= '0;
      reqAddr   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; these two defaults make
      // ready/err single-cycle pulses unless a transition below sets them.
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (decHit) begin
              dev_sel   <= N_DEV'(1) << decIdx;
              dev_we    <= cpu_we;
              dev_be    <= cpu_be;
              dev_addr  <= decOffset;
              dev_wdata <= cpu_wdata;
`ifdef BRIDGE_TIMEOUT_EN
              waitCnt   <= '0;
              reqAddr   <= cpu_addr;
`endif
              state     <= ACCESS;
            end else begin
              cpu_rdata <= '0;
              cpu_err   <= 1'b1;
              cpu_ready <= 1'b1;
              err_addr  <= cpu_addr;
              state     <= RESP;
            end
          end
        end

        ACCESS: begin
          if (ackHit) begin
            cpu_rdata <= dev_we ? '0 : selRdata;
            cpu_ready <= 1'b1;
            dev_sel   <= '0;
            state     <= RESP;
          end
`ifdef BRIDGE_TIMEOUT_EN
          else if (timeoutHit) begin
            cpu_rdata <= '0;
            cpu_err   <= 1'b1;
            cpu_ready <= 1'b1;
            err_addr  <= reqAddr;
            dev_sel   <= '0;
            state     <= RESP;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
`endif
        end

        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_io_bus_bridge
// Self-checking bench for io_bus_bridge (4 devices, base 0x7F00, 16-byte
// windows, timeout 8 when BRIDGE_TIMEOUT_EN is defined). The bench plays both
// the CPU and the devices; expected results come from a window-arithmetic
// reference model. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_io_bus_bridge;

  localparam int          NDEV = 4;
  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam int          TO   = 8;
`ifdef BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req;
  logic              cpu_we;
  logic [31:2]       cpu_addr;
  logic [3:0]        cpu_be;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              cpu_err;
  logic [NDEV-1:0]   dev_sel;
  logic              dev_we;
  logic [3:0]        dev_be;
  logic [3:2]        dev_addr;
  logic [31:0]       dev_wdata;
  logic [NDEV*32-1:0] dev_rdata;
  logic [NDEV-1:0]   dev_ack;
  logic [31:2]       err_addr;

  int passCnt  = 0;
  int totalCnt = 0;
  logic [31:2] modelErrAddr = '0;

  io_bus_bridge #(
    .N_DEV          (NDEV),
    .BASE_ADDR      (BASE),
    .WIN_WORDS_LOG2 (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_be    (cpu_be),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .dev_sel   (dev_sel),
    .dev_we    (dev_we),
    .dev_be    (dev_be),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata),
    .dev_ack   (dev_ack),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

  // One complete CPU access. The bench acts as the device, acking on ACCESS
  // cycle waits+1 and driving the 'spurious' ack bits on other devices.
  task automatic run_access(input string name, input logic we, input logic [31:0] byteAddr,
                            input logic [3:0] be, input logic [31:0] wdata, input int waits,
                            input logic [31:0] rdataVal, input logic [3:0] spurious);
    logic [31:0] off, expRdata;
    logic [3:0]  expSel;
    bit          hit, timedOut, expErr;
    int          dev, expLat, cycles, accCycles;
    off      = byteAddr - BASE;
    hit      = (byteAddr >= BASE) && (off / 16 < NDEV);
    dev      = hit ? int'(off / 16) : 0;
    expSel   = hit ? 4'(1 << dev) : 4'b0;
    timedOut = TO_EN && hit && (waits >= TO);
    expLat   = !hit ? 1 : (timedOut ? TO + 1 : waits + 2);
    expErr   = !hit || timedOut;
    expRdata = (hit && !we && !timedOut) ? rdataVal : 32'h0;
    if (expErr) modelErrAddr = byteAddr[31:2];

    for (int i = 0; i < NDEV; i++) dev_rdata[i*32 +: 32] = $urandom;
    dev_rdata[dev*32 +: 32] = rdataVal;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = byteAddr[31:2]; cpu_be = be; cpu_wdata = wdata;
    dev_ack = '0;
    cycles = 0; accCycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (!cpu_ready) begin
        accCycles++;
        totalCnt++;
        if (!hit && dev_sel !== 4'b0)
          $display("FAIL %s dev_sel on miss: got %b want 0000", name, dev_sel);
        else if (hit && {dev_sel, dev_we, dev_be, dev_addr, dev_wdata} !== {expSel, we, be, off[3:2], wdata})
          $display("FAIL %s dev outputs cycle %0d: got %b/%b/%h/%0d/%h want %b/%b/%h/%0d/%h", name,
                   accCycles, dev_sel, dev_we, dev_be, dev_addr, dev_wdata, expSel, we, be, off[3:2], wdata);
        else passCnt++;
        dev_ack = spurious & ~expSel;
        if (hit && accCycles == waits + 1) dev_ack = dev_ack | expSel;
      end
    end while (!cpu_ready && cycles < 60);

    totalCnt++;
    if (cycles !== expLat) $display("FAIL %s latency: got %0d want %0d", name, cycles, expLat);
    else passCnt++;
    totalCnt++;
    if ({cpu_err, cpu_rdata} !== {expErr, expRdata})
      $display("FAIL %s response: got err=%b rdata=%h want err=%b rdata=%h", name, cpu_err, cpu_rdata, expErr, expRdata);
    else passCnt++;
    totalCnt++;
    if (err_addr !== modelErrAddr) $display("FAIL %s err_addr: got %h want %h", name, err_addr, modelErrAddr);
    else passCnt++;
    totalCnt++;
    if (dev_sel !== 4'b0) $display("FAIL %s dev_sel in RESP: got %b want 0000", name, dev_sel);
    else passCnt++;

    cpu_req = 1'b0; dev_ack = '0;
    @(negedge clk);
    totalCnt++;
    if ({cpu_ready, cpu_err, cpu_rdata} !== {2'b00, expRdata})
      $display("FAIL %s after RESP: got ready=%b err=%b rdata=%h want 0/0/%h", name, cpu_ready, cpu_err, cpu_rdata, expRdata);
    else passCnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
    dev_rdata = '0; dev_ack = '0;
    repeat (2) @(negedge clk);
    totalCnt++;
    if ({cpu_rdata, cpu_ready, cpu_err, dev_sel, dev_we, dev_be, dev_addr, dev_wdata, err_addr} !== '0)
      $display("FAIL reset outputs: got rdata=%h rdy=%b err=%b sel=%b wdata=%h err_addr=%h want all 0",
               cpu_rdata, cpu_ready, cpu_err, dev_sel, dev_wdata, err_addr);
    else passCnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    run_access("read_dev1", 1'b0, 32'h7F14, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 4'b0000);
  endtask

  task automatic test_write_wait();
    run_access("write_dev3_wait3", 1'b1, 32'h7F30, 4'b0011, 32'h1234_5678, 3, 32'h5555_AAAA, 4'b0000);
  endtask

  task automatic test_miss();
    run_access("miss_idx4", 1'b0, 32'h7F40, 4'hF, 32'h0, 0, 32'h1111_1111, 4'b0000);
    run_access("miss_below", 1'b1, 32'h7EFC, 4'hF, 32'h9, 0, 32'h2222_2222, 4'b0000);
    run_access("miss_top", 1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0, 0, 32'h3333_3333, 4'b0000);
    run_access("miss_zero", 1'b0, 32'h0000_0000, 4'hF, 32'h0, 0, 32'h4444_4444, 4'b0000);
  endtask

  task automatic test_spurious_ack();
    run_access("spurious_dev2", 1'b0, 32'h7F08, 4'hF, 32'h0, 2, 32'h0BAD_F00D, 4'b0100);
    run_access("spurious_all", 1'b0, 32'h7F28, 4'hF, 32'h0, 1, 32'hFACE_0001, 4'b1111);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    int cyc, lastReady, readies;
    addrs[0] = 32'h7F00; addrs[1] = 32'h7F1C; addrs[2] = 32'h7F24;
    for (int i = 0; i < NDEV; i++) dev_rdata[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = addrs[0][31:2]; dev_ack = '0;
    cyc = 0; lastReady = 0; readies = 0;
    while (readies < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cpu_ready) begin
        totalCnt++;
        if (cpu_rdata !== (32'hA5A5_0000 | 32'(readies)))
          $display("FAIL b2b rdata %0d: got %h want %h", readies, cpu_rdata, 32'hA5A5_0000 | 32'(readies));
        else passCnt++;
        totalCnt++;
        if (cyc - lastReady !== ((readies == 0) ? 2 : 3))
          $display("FAIL b2b spacing %0d: got %0d want %0d", readies, cyc - lastReady, (readies == 0) ? 2 : 3);
        else passCnt++;
        lastReady = cyc;
        readies++;
        if (readies < 3) cpu_addr = addrs[readies][31:2];
        dev_ack = '0;
      end else begin
        dev_ack = dev_sel;
      end
    end
    cpu_req = 1'b0; dev_ack = '0;
    totalCnt++;
    if (readies !== 3) $display("FAIL b2b completions: got %0d want 3", readies);
    else passCnt++;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int kind;
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 5);
      if (kind <= 3)      a = BASE + 32'($urandom_range(0, NDEV - 1) * 16) + 32'($urandom_range(0, 3) * 4);
      else if (kind == 4) a = BASE + 32'h40 + 32'($urandom_range(0, 4000) * 4);
      else                a = 32'($urandom_range(0, int'(BASE / 4) - 1) * 4);
      run_access("random", 1'($urandom), a, 4'($urandom), $urandom, $urandom_range(0, 3), $urandom,
                 4'($urandom));
    end
  endtask

  task automatic test_timeout();
    run_access("timeout_noack", 1'b0, 32'h7F24, 4'hF, 32'h0, 1000, 32'h7777_7777, 4'b0000);
    run_access("after_timeout", 1'b0, 32'h7F04, 4'hF, 32'h0, 0, 32'h0123_4567, 4'b0000);
    run_access("ack_at_limit", 1'b1, 32'h7F3C, 4'hC, 32'hCAFE_CAFE, TO - 1, 32'h8888_8888, 4'b0000);
  endtask

  task automatic test_reset_mid_access();
    run_access("pre_reset_read", 1'b0, 32'h7F18, 4'hF, 32'h0, 0, 32'hCAFE_F00D, 4'b0000);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 30'(32'h7F20 >> 2); cpu_be = 4'hF; cpu_wdata = 32'hFEED_0001;
    dev_ack = '0;
    repeat (TO_EN ? 5 : 40) @(negedge clk);
    totalCnt++;
    if ({dev_sel, cpu_ready} !== {4'b0100, 1'b0})
      $display("FAIL stalled access: got sel=%b ready=%b want 0100/0", dev_sel, cpu_ready);
    else passCnt++;
    #2 rst_n = 1'b0;
    #1;
    totalCnt++;
    if ({dev_sel, cpu_ready, cpu_err, cpu_rdata, err_addr} !== '0)
      $display("FAIL async reset: got sel=%b ready=%b err=%b rdata=%h err_addr=%h want all 0",
               dev_sel, cpu_ready, cpu_err, cpu_rdata, err_addr);
    else passCnt++;
    modelErrAddr = '0;
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_access("post_reset_read", 1'b0, 32'h7F2C, 4'hF, 32'h0, 1, 32'h600D_0002, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_miss();
    test_spurious_ack();
    test_back_to_back();
    test_random();
    if (TO_EN) test_timeout();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
